// File: rtl/sys_arr_pkg.sv
// Shared constants and FSM state type for the systolic-array output path.
package sys_arr_pkg;

  localparam int SYS_COL_DEF    = 16;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/out_col_writer.sv
// One output column: row counter plus registered write port into its memory bank.
// OUT_WR_RELU_EN defined: negative results are written as zero.
module out_col_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  drain_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH:0]   rows_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  full_d_o,
  output logic                  ovf_o
);

  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] data_m;
  logic                  full, accept;

`ifdef OUT_WR_RELU_EN
  assign data_m = data_i[DATA_WIDTH-1] ? '0 : data_i;
`else
  assign data_m = data_i;
`endif

  assign full   = (cnt_q == rows_i);
  assign accept = drain_i && valid_i && !full;
  assign ovf_o  = drain_i && valid_i && full;

  always_comb begin
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d     = cnt_q + (ADDR_WIDTH+1)'(1);
      wr_en_d   = 1'b1;
      // Address arithmetic deliberately wraps within the bank.
      wr_addr_d = base_i + cnt_q[ADDR_WIDTH-1:0];
      wr_data_d = data_m;
    end
  end

  // Lets the FSM leave DRAIN on the same edge that launches the final write.
  assign full_d_o = (cnt_d == rows_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: rtl/out_mem_writer.sv
// Drains column-skewed systolic results into per-column memory banks.
// Valid/ready: in_valid[j] is a one-cycle push with no back-pressure; write data follows one cycle later.
module out_mem_writer
  import sys_arr_pkg::*;
#(
  parameter int SYS_COL    = SYS_COL_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_rows,
  input  logic [SYS_COL-1:0]    in_valid,
  input  logic [DATA_WIDTH-1:0] in_data [0:SYS_COL-1],
  output logic [SYS_COL-1:0]    wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr [0:SYS_COL-1],
  output logic [DATA_WIDTH-1:0] wr_data [0:SYS_COL-1],
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output wr_state_e             dbg_state
);

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   rows_q, rows_d;
  logic                  ovf_q, ovf_d;
  logic                  accept_start;
  logic                  drain;
  logic [SYS_COL-1:0]    full_d;
  logic [SYS_COL-1:0]    ovf_col;

  assign accept_start = (state_q == ST_IDLE) && start;
  assign drain        = (state_q == ST_DRAIN);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    rows_d  = rows_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          rows_d  = num_rows;
          ovf_d   = 1'b0;
          state_d = (num_rows == '0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (|ovf_col) ovf_d = 1'b1;
        if (&full_d) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      rows_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rows_q  <= rows_d;
      ovf_q   <= ovf_d;
    end
  end

  for (genvar j = 0; j < SYS_COL; j++) begin : g_col
    out_col_writer #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_col (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (accept_start),
      .drain_i   (drain),
      .valid_i   (in_valid[j]),
      .data_i    (in_data[j]),
      .base_i    (base_q),
      .rows_i    (rows_q),
      .wr_en_o   (wr_en[j]),
      .wr_addr_o (wr_addr[j]),
      .wr_data_o (wr_data[j]),
      .full_d_o  (full_d[j]),
      .ovf_o     (ovf_col[j])
    );
  end

  assign busy      = drain;
  assign done      = (state_q == ST_DONE);
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_out_mem_writer.sv
// Scoreboard bench for out_mem_writer: expected writes queued at stimulus time, popped as banks are written.
module tb_out_mem_writer;
  import sys_arr_pkg::*;

  localparam int C  = 16;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int W  = 4 + AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_rows;
  logic [C-1:0]  in_valid;
  logic [DW-1:0] in_data [0:C-1];
  logic [C-1:0]  wr_en;
  logic [AW-1:0] wr_addr [0:C-1];
  logic [DW-1:0] wr_data [0:C-1];
  logic          busy, done, overflow;
  wr_state_e     dbg_state;

  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad   = 0;
  int           k_m [0:C-1];
  int           rows_m;
  logic [AW-1:0] base_m;

  out_mem_writer #(.SYS_COL(C), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .in_valid(in_valid), .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] relu_m(input logic [DW-1:0] d);
`ifdef OUT_WR_RELU_EN
    return ($signed(d) < 0) ? '0 : d;
`else
    return d;
`endif
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = '0;
  endtask

  task automatic start_run(input logic [AW-1:0] b, input int r);
    start     = 1'b1;
    base_addr = b;
    num_rows  = 9'(r);
    base_m    = b;
    rows_m    = r;
    for (int j = 0; j < C; j++) k_m[j] = 0;
    tick();
  endtask

  task automatic col_val(input int j, input logic [DW-1:0] d);
    in_valid[j] = 1'b1;
    in_data[j]  = d;
    if (k_m[j] < rows_m)
      exp_q.push_back({4'(j), AW'(int'(base_m) + k_m[j]), relu_m(d)});
    k_m[j]++;
  endtask

  // scoreboard: pop one expected write per observed bank write
  always @(negedge clk) begin
    for (int j = 0; j < C; j++) begin
      if (wr_en[j] === 1'b1) begin
        if (exp_q.size() == 0) chk("wr_extra_bank", 32'(wr_en[j]), 32'd0);
        else chk("wr", 32'({4'(j), wr_addr[j], wr_data[j]}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; in_valid = '0;
    for (int j = 0; j < C; j++) in_data[j] = '0;
    rows_m = 0; base_m = '0;
    for (int j = 0; j < C; j++) k_m[j] = 0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // unskewed full drain
    start_run(8'h00, 16);
    chk("unsk_busy0", 32'(busy), 1);
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < C; j++) col_val(j, DW'(4 * j + i));
      tick();
      chk("unsk_done", 32'(done), 32'(i == 15));
      chk("unsk_busy", 32'(busy), 32'(i < 15));
    end
    tick();
    chk("unsk_done_pulse", 32'(done), 0);
    chk("unsk_q_empty", 32'(exp_q.size()), 0);

    // skewed arrival
    start_run(8'h00, 4);
    for (int t = 0; t < 19; t++) begin
      for (int j = 0; j < C; j++)
        if (t - j >= 0 && t - j < 4) col_val(j, DW'(256 * j + (t - j)));
      tick();
      chk("skew_done", 32'(done), 32'(t == 18));
      chk("skew_busy", 32'(busy), 32'(t < 18));
    end
    tick();
    chk("skew_q_empty", 32'(exp_q.size()), 0);

    // address wrap
    start_run(8'hFE, 3);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < C; j++) col_val(j, DW'($urandom_range(0, 16'h7FFF)));
      tick();
    end
    chk("wrap_done", 32'(done), 1);
    chk("wrap_ovf", 32'(overflow), 0);
    tick();
    chk("wrap_q_empty", 32'(exp_q.size()), 0);

    // overflow on column 3
    start_run(8'h00, 2);
    for (int j = 0; j < C; j++) col_val(j, DW'($urandom_range(0, 1000)));
    tick();
    col_val(3, 16'h0123);
    tick();
    chk("ovf_pre", 32'(overflow), 0);
    col_val(3, 16'h0456);
    tick();
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_busy", 32'(busy), 1);
    for (int j = 0; j < C; j++) if (j != 3) col_val(j, DW'(j + 7));
    tick();
    chk("ovf_done", 32'(done), 1);
    chk("ovf_sticky_done", 32'(overflow), 1);
    tick();
    in_valid = '1;  // ignored in IDLE: no write, no error
    tick();
    tick();
    chk("ovf_sticky_idle", 32'(overflow), 1);
    chk("ovf_q_empty", 32'(exp_q.size()), 0);

    // zero rows
    start_run(8'h33, 0);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_ovf_clr", 32'(overflow), 0);
    tick();
    chk("zero_done_pulse", 32'(done), 0);
    chk("zero_state", 32'(dbg_state), 32'(ST_IDLE));

    // start ignored during DRAIN
    start_run(8'h10, 2);
    for (int j = 0; j < C; j++) col_val(j, DW'(j));
    start = 1'b1; base_addr = 8'h80; num_rows = 9'd5;
    tick();
    chk("restart_busy", 32'(busy), 1);
    for (int j = 0; j < C; j++) col_val(j, DW'(j + 100));
    tick();
    chk("restart_done", 32'(done), 1);
    tick();
    chk("restart_q_empty", 32'(exp_q.size()), 0);

    // reset mid-DRAIN after 5 writes
    start_run(8'h20, 8);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < C; j++) col_val(j, DW'(i * 16 + j));
      tick();
    end
    rst = 1'b1;
    in_valid = '1;
    tick();
    chk("mrst_wr_en", 32'(wr_en), 0);
    for (int j = 0; j < C; j++) begin
      chk("mrst_addr", 32'(wr_addr[j]), 0);
      chk("mrst_data", 32'(wr_data[j]), 0);
    end
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_ovf", 32'(overflow), 0);
    chk("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();
    start_run(8'h40, 2);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < C; j++) col_val(j, DW'($urandom_range(0, 16'h7FFF)));
      tick();
    end
    chk("mrst_run_done", 32'(done), 1);
    tick();
    chk("mrst_q_empty", 32'(exp_q.size()), 0);

    // negative data (zeroed when ReLU is built in)
    start_run(8'h05, 1);
    for (int j = 0; j < C; j++) col_val(j, 16'hFFF0);
    tick();
    chk("neg_done", 32'(done), 1);
    tick();
    tick();
    chk("final_q_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
